// File: rtl/perf_pkg.sv
// Shared types and constants for the writeback retire monitor and its counters.
package perf_pkg;

  localparam int CNT_W = 64;
  localparam int N_CNT = 4;

  localparam logic [31:0] HALT_PC0_DEF = 32'h0000_001C;
  localparam logic [31:0] HALT_PC1_DEF = 32'h0000_0020;

  typedef enum logic [1:0] {
    CNT_CYCLE   = 2'd0,
    CNT_INSTRET = 2'd1,
    CNT_CTRL    = 2'd2,
    CNT_MISPRED = 2'd3
  } cnt_sel_e;

  // The read port is 32 bits wide, so software sees a counter one half at a time.
  function automatic logic [31:0] cnt_half(input logic [CNT_W-1:0] v, input logic hi);
    return hi ? v[63:32] : v[31:0];
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrapping counter; clear beats hold, hold beats increment.
module perf_counter
  import perf_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         hold_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i && inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/commit_monitor.sv
// Writeback retire stage: registers MEM->WB, drives the retire stream, keeps
// four performance counters behind a registered read port and a sticky halt flag.
module commit_monitor
  import perf_pkg::*;
#(
  parameter logic [31:0] HALT_PC0 = perf_pkg::HALT_PC0_DEF,
  parameter logic [31:0] HALT_PC1 = perf_pkg::HALT_PC1_DEF,
  parameter int          CNT_W    = perf_pkg::CNT_W
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_vld,
  input  logic [31:0] i_mem_pc,
  input  logic        i_mem_ctrl,
  input  logic        i_mem_mispred,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_cnt_freeze,
  input  logic        i_cnt_clr,
  input  logic [1:0]  i_rd_addr,
  input  logic        i_rd_hi,
  output logic [31:0] o_rd_data,
  output logic        o_insn_vld,
  output logic [31:0] o_pc_debug,
  output logic        o_ctrl,
  output logic        o_mispred,
  output logic        o_halt
);

  logic        vld_q, vld_d;
  logic [31:0] pc_q, pc_d;
  logic        ctrl_q, ctrl_d;
  logic        mispred_q, mispred_d;
  logic        halt_q, halt_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [N_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_val [N_CNT];
  logic             cnt_hold;

  always_comb begin
    vld_d     = i_mem_vld & ~i_stall & ~i_flush;
    pc_d      = i_mem_pc;
    ctrl_d    = i_mem_ctrl & vld_d;
    // A mispredict flag on a non-control instruction carries no meaning.
    mispred_d = i_mem_mispred & i_mem_ctrl & vld_d;
    halt_d    = halt_q | (vld_q & ((pc_q == HALT_PC0) | (pc_q == HALT_PC1)));
    rd_data_d = cnt_half(cnt_val[i_rd_addr], i_rd_hi);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q     <= 1'b0;
      pc_q      <= '0;
      ctrl_q    <= 1'b0;
      mispred_q <= 1'b0;
      halt_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      vld_q     <= vld_d;
      pc_q      <= pc_d;
      ctrl_q    <= ctrl_d;
      mispred_q <= mispred_d;
      halt_q    <= halt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Counters see the retiring instruction, so they lag the retire stream by one edge.
  assign cnt_inc[CNT_CYCLE]   = 1'b1;
  assign cnt_inc[CNT_INSTRET] = vld_q;
  assign cnt_inc[CNT_CTRL]    = vld_q & ctrl_q;
  assign cnt_inc[CNT_MISPRED] = mispred_q;
  assign cnt_hold             = i_cnt_freeze | halt_q;

  for (genvar gi = 0; gi < N_CNT; gi++) begin : gen_cnt
    perf_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk_i (i_clk),
      .rst_i (i_reset),
      .clr_i (i_cnt_clr),
      .hold_i(cnt_hold),
      .inc_i (cnt_inc[gi]),
      .cnt_o (cnt_val[gi])
    );
  end

  assign o_rd_data  = rd_data_q;
  assign o_insn_vld = vld_q;
  assign o_pc_debug = pc_q;
  assign o_ctrl     = ctrl_q;
  assign o_mispred  = mispred_q;
  assign o_halt     = halt_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: directed tables, hand sequences and random traffic
// compared against a cycle-level reference model of the retire/counter rules.
module tb_commit_monitor;
  import perf_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_vld, mem_ctrl, mem_mis, stall, flush, freeze, clr, rd_hi;
  logic [31:0] mem_pc;
  logic [1:0]  rd_addr;
  logic [31:0] o_rd_data, o_pc_debug;
  logic        o_insn_vld, o_ctrl, o_mispred, o_halt;

  commit_monitor dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_mem_vld    (mem_vld),
    .i_mem_pc     (mem_pc),
    .i_mem_ctrl   (mem_ctrl),
    .i_mem_mispred(mem_mis),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_cnt_freeze (freeze),
    .i_cnt_clr    (clr),
    .i_rd_addr    (rd_addr),
    .i_rd_hi      (rd_hi),
    .o_rd_data    (o_rd_data),
    .o_insn_vld   (o_insn_vld),
    .o_pc_debug   (o_pc_debug),
    .o_ctrl       (o_ctrl),
    .o_mispred    (o_mispred),
    .o_halt       (o_halt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_cyc  = 0;

  // Reference model state: architectural view of what the monitor should show.
  logic [63:0] m_cnt [4];
  logic        m_vld, m_ctrl, m_mis, m_halt;
  logic [31:0] m_pc, m_rd;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  inb;   // {vld, ctrl, mispred, stall, flush}
    logic [2:0]  expo;  // {insn_vld, ctrl, mispred}
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic model_edge();
    logic [63:0] sel;
    logic        retire_halt;
    if (reset) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = '0;
      {m_vld, m_ctrl, m_mis, m_halt} = '0;
      m_pc = '0;
      m_rd = '0;
    end else begin
      sel  = m_cnt[rd_addr];
      m_rd = rd_hi ? sel[63:32] : sel[31:0];
      retire_halt = m_vld && (m_pc == 32'h1C || m_pc == 32'h20);
      if (clr) begin
        for (int k = 0; k < 4; k++) m_cnt[k] = '0;
      end else if (!(freeze || m_halt)) begin
        m_cnt[0] = m_cnt[0] + 64'd1;
        if (m_vld)           m_cnt[1] = m_cnt[1] + 64'd1;
        if (m_vld && m_ctrl) m_cnt[2] = m_cnt[2] + 64'd1;
        if (m_mis)           m_cnt[3] = m_cnt[3] + 64'd1;
      end
      if (retire_halt) m_halt = 1'b1;
      m_vld  = mem_vld && !stall && !flush;
      m_pc   = mem_pc;
      m_ctrl = m_vld && mem_ctrl;
      m_mis  = m_vld && mem_ctrl && mem_mis;
    end
  endtask

  // One clock: advance model and DUT together, then compare every output.
  task automatic cyc();
    logic [67:0] got, exp;
    @(posedge clk);
    model_edge();
    #1;
    n_cyc++;
    got = {o_insn_vld, o_ctrl, o_mispred, o_halt, o_pc_debug, o_rd_data};
    exp = {m_vld, m_ctrl, m_mis, m_halt, m_pc, m_rd};
    $display("cyc %0d rst=%b vld=%b pc=%08h st=%b fl=%b clr=%b frz=%b -> vld=%b pc=%08h c=%b m=%b halt=%b rd=%08h",
             n_cyc, reset, mem_vld, mem_pc, stall, flush, clr, freeze,
             o_insn_vld, o_pc_debug, o_ctrl, o_mispred, o_halt, o_rd_data);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL model@%0d: got {vld,c,m,halt,pc,rd}=%017h expected %017h", n_cyc, got, exp);
  endtask

  task automatic idle();
    {reset, mem_vld, mem_ctrl, mem_mis, stall, flush, freeze, clr} = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic h, input logic [31:0] exp, input string name);
    idle();
    rd_addr = a;
    rd_hi   = h;
    cyc();
    check(name, o_rd_data, exp);
  endtask

  initial begin
    int mis_pulses;

    tbl[0]  = '{32'h80, 5'b10000, 3'b100};
    tbl[1]  = '{32'h84, 5'b10000, 3'b100};
    tbl[2]  = '{32'h88, 5'b10010, 3'b000};
    tbl[3]  = '{32'h8C, 5'b10000, 3'b100};
    tbl[4]  = '{32'h90, 5'b11101, 3'b000};
    tbl[5]  = '{32'h94, 5'b10000, 3'b100};
    tbl[6]  = '{32'h98, 5'b10000, 3'b100};
    tbl[7]  = '{32'h9C, 5'b10000, 3'b100};
    tbl[8]  = '{32'hA0, 5'b10000, 3'b100};
    tbl[9]  = '{32'hA4, 5'b10000, 3'b100};
    tbl[10] = '{32'hB0, 5'b11000, 3'b110};
    tbl[11] = '{32'hB4, 5'b11100, 3'b111};
    tbl[12] = '{32'hB8, 5'b11000, 3'b110};
    tbl[13] = '{32'hBC, 5'b10100, 3'b100};
    tbl[14] = '{32'hC0, 5'b11100, 3'b111};
    tbl[15] = '{32'hC4, 5'b11000, 3'b110};
    tbl[16] = '{32'hC8, 5'b11000, 3'b110};
    tbl[17] = '{32'hD0, 5'b11111, 3'b000};
    tbl[18] = '{32'hD4, 5'b01100, 3'b000};

    idle();
    mem_pc  = '0;
    rd_addr = '0;
    rd_hi   = 1'b0;
    reset   = 1'b1;
    cyc();
    cyc();
    check("reset_outputs", {26'd0, o_insn_vld, o_ctrl, o_mispred, o_halt, o_rd_data[1:0]}, 32'd0);
    check("reset_pc", o_pc_debug, 32'd0);
    check("reset_rd", o_rd_data, 32'd0);

    // Straight-line retire.
    idle();
    for (int i = 0; i < 10; i++) begin
      mem_vld = 1'b1;
      mem_pc  = 32'h40 + 32'(4 * i);
      cyc();
      check($sformatf("straight_vld%0d", i), 32'(o_insn_vld), 32'd1);
      check($sformatf("straight_pc%0d", i), o_pc_debug, 32'h40 + 32'(4 * i));
    end
    idle();
    cyc();
    rd(2'd1, 1'b0, 32'd10, "instret_straight");
    rd(2'd1, 1'b1, 32'd0, "instret_straight_hi");

    // Stall/flush and branch accounting table.
    idle();
    clr = 1'b1;
    cyc();
    mis_pulses = 0;
    for (int i = 0; i < 19; i++) begin
      if (i == 10) begin
        idle();
        cyc();
        rd(2'd1, 1'b0, 32'd8, "instret_stall_flush");
        rd(2'd2, 1'b0, 32'd0, "ctrl_after_flush");
        rd(2'd3, 1'b0, 32'd0, "mispred_after_flush");
      end
      idle();
      mem_pc = tbl[i].pc;
      {mem_vld, mem_ctrl, mem_mis, stall, flush} = tbl[i].inb;
      cyc();
      if (o_mispred) mis_pulses++;
      check($sformatf("tbl%0d", i), {o_insn_vld, o_ctrl, o_mispred, o_pc_debug[28:0]},
            {tbl[i].expo, tbl[i].pc[28:0]});
    end
    idle();
    cyc();
    check("mispred_pulses", 32'(mis_pulses), 32'd2);
    rd(2'd1, 1'b0, 32'd15, "instret_branch");
    rd(2'd2, 1'b0, 32'd6, "ctrl_branch");
    rd(2'd3, 1'b0, 32'd2, "mispred_branch");

    // Clear on the same edge as an instret increment.
    idle();
    mem_vld = 1'b1;
    mem_pc  = 32'h100;
    cyc();
    idle();
    clr = 1'b1;
    cyc();
    rd(2'd1, 1'b0, 32'd0, "clr_instret");
    rd(2'd0, 1'b0, 32'd1, "cycle_after_clr");
    check("halt_clear_before", 32'(o_halt), 32'd0);

    // Halt: the halting instruction counts, then everything freezes.
    idle();
    mem_vld = 1'b1;
    mem_pc  = 32'h1C;
    cyc();
    check("halt_not_yet", 32'(o_halt), 32'd0);
    mem_pc = 32'h200;
    cyc();
    check("halt_set", 32'(o_halt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_vld = 1'b1;
      mem_pc  = 32'h300 + 32'(4 * i);
      cyc();
      check($sformatf("halt_stream%0d", i), {31'd0, o_insn_vld}, 32'd1);
    end
    rd(2'd0, 1'b0, 32'd4, "cycle_frozen");
    rd(2'd1, 1'b0, 32'd1, "instret_frozen");
    idle();
    clr = 1'b1;
    cyc();
    check("halt_kept_on_clr", 32'(o_halt), 32'd1);
    rd(2'd0, 1'b0, 32'd0, "cycle_clr_halted");
    rd(2'd0, 1'b0, 32'd0, "cycle_still_frozen");

    // Reset in the middle of a stream.
    idle();
    mem_vld = 1'b1;
    mem_pc  = 32'h400;
    cyc();
    mem_pc = 32'h404;
    reset  = 1'b1;
    cyc();
    check("reset_mid", {o_insn_vld, o_ctrl, o_mispred, o_halt, o_pc_debug[27:0]}, 32'd0);
    check("reset_mid_rd", o_rd_data, 32'd0);

    // Cycle counter wrap through the read port.
    idle();
    rd_addr = 2'd0;
    rd_hi   = 1'b0;
    force dut.gen_cnt[0].u_cnt.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    freeze = 1'b1;
    cyc();
    release dut.gen_cnt[0].u_cnt.cnt_q;
    check("wrap_lo_forced", o_rd_data, 32'hFFFF_FFFF);
    rd_hi = 1'b1;
    cyc();
    check("wrap_hi_forced", o_rd_data, 32'hFFFF_FFFF);
    freeze = 1'b0;
    rd_hi  = 1'b0;
    cyc();
    check("wrap_lo_pre", o_rd_data, 32'hFFFF_FFFF);
    cyc();
    check("wrap_lo_post", o_rd_data, 32'h0000_0000);
    rd_hi = 1'b1;
    cyc();
    check("wrap_hi_post", o_rd_data, 32'h0000_0000);

    // Random traffic against the model.
    idle();
    reset = 1'b1;
    cyc();
    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      mem_vld  = ($urandom_range(0, 99) < 75);
      case ($urandom_range(0, 59))
        0:       mem_pc = 32'h1C;
        1:       mem_pc = 32'h20;
        default: mem_pc = {$urandom_range(0, 4095), 2'b00};
      endcase
      mem_ctrl = ($urandom_range(0, 99) < 30);
      mem_mis  = ($urandom_range(0, 99) < 50);
      stall    = ($urandom_range(0, 99) < 10);
      flush    = ($urandom_range(0, 99) < 10);
      freeze   = ($urandom_range(0, 99) < 5);
      clr      = ($urandom_range(0, 99) < 2);
      rd_addr  = 2'($urandom_range(0, 3));
      rd_hi    = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Writeback-boundary retire unit of the 5-stage RV32 pipeline. It registers the MEM→WB instruction, drops bubbles, stalls and flushes, and drives the per-instruction retire stream (`o_insn_vld`, `o_pc_debug`, `o_ctrl`, `o_mispred`) that the testbench monitor consumes. It also keeps four 64-bit performance counters behind a registered read port, and raises a sticky halt flag when a retiring PC matches a halt address. After halt, all counters freeze so the final statistics stay stable.

## Interface
Parameters:
- `HALT_PC0`, default `32'h0000_001C`: first halt address.
- `HALT_PC1`, default `32'h0000_0020`: second halt address.
- `CNT_W`, default `64`: counter width. Fixed at 64; the read port splits it into two 32-bit halves.

Ports:
- `i_clk`  in  1  sole clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_mem_vld`  in  1  MEM stage holds a real instruction.
- `i_mem_pc`  in  32  PC of the MEM instruction.
- `i_mem_ctrl`  in  1  MEM instruction is a branch or jump.
- `i_mem_mispred`  in  1  MEM instruction was mispredicted.
- `i_stall`  in  1  MEM not advancing this cycle.
- `i_flush`  in  1  kill the instruction entering WB.
- `i_cnt_freeze`  in  1  hold all counters.
- `i_cnt_clr`  in  1  zero all counters.
- `i_rd_addr`  in  2  counter select: 0 cycle, 1 instret, 2 ctrl, 3 mispred.
- `i_rd_hi`  in  1  1 selects bits [63:32], 0 selects bits [31:0].
- `o_rd_data`  out  32  registered counter read data.
- `o_insn_vld`  out  1  an instruction retires this cycle.
- `o_pc_debug`  out  32  PC of the retiring instruction.
- `o_ctrl`  out  1  the retiring instruction is a control instruction.
- `o_mispred`  out  1  the retiring control instruction was mispredicted.
- `o_halt`  out  1  sticky halt flag.

## Operation
- **Reset values:** all outputs are 0; all counters and the halt flag are 0.
- **WB register update:** `vld_n = i_mem_vld & ~i_stall & ~i_flush`.
  - Flush and stall each insert a bubble; when both are asserted, a single bubble results.
  - The PC is loaded every cycle regardless of `vld_n`.
  - `ctrl` is loaded as `i_mem_ctrl & vld_n`.
  - `mispred` is loaded as `i_mem_mispred & i_mem_ctrl & vld_n`. A mispredict without ctrl is discarded.
- **Counter increments** (each counter wraps from 2^64−1 to 0):
  - cycle: +1 on every non-reset cycle.
  - instret: +1 when `o_insn_vld`.
  - ctrl: +1 when `o_insn_vld & o_ctrl`.
  - mispred: +1 when `o_mispred`.
- **Counter priority:** `i_cnt_clr`, then `(i_cnt_freeze | o_halt)`, then increment.
- **Halt:** `o_halt` sets when `o_insn_vld` and `o_pc_debug` equals `HALT_PC0` or `HALT_PC1`. It clears only on `i_reset`; `i_cnt_clr` does not clear it.
  - The halting instruction itself is counted.
  - Freezing takes effect from the next cycle.
- **Read port:** `o_rd_data <= sel(i_rd_addr, i_rd_hi)`. It samples counter values as they stand before this edge's update.
- **Retire stream after halt:** retire outputs keep tracking the pipeline; only the counters freeze.

## Timing
- MEM→retire latency is 1 cycle. An instruction sampled at edge N appears on `o_insn_vld` and `o_pc_debug` during cycle N+1.
- Counter update lags retire by 1 edge: instret reflects a retire at N+1 from edge N+2.
- Read latency is 1 cycle. The address presented at edge N produces data after edge N. That data is the count before any increment at edge N.
- **Reset mid-operation:** the next cycle shows a bubble, zero counters, and `o_halt` = 0. An in-flight instruction is lost.
- **Clear and increment in the same cycle:** the counter reads 0 afterwards; the increment is dropped.
- **Hi/lo read:** the two halves are not atomic. Software reads hi, lo, hi again and retries on mismatch.

## Structure
- **Package `perf_pkg`:**
  - `cnt_sel_e` enum: `CNT_CYCLE`=0, `CNT_INSTRET`=1, `CNT_CTRL`=2, `CNT_MISPRED`=3.
  - `CNT_W`=64.
  - Default halt-PC localparams.
- **Sub-module `perf_counter`:** 64-bit counter with clr, hold and inc inputs, clr > hold > inc, synchronous active-high reset. Instantiated 4×.
- **Top level:** holds the WB register, the halt compare and flag, and the read mux plus output register.

## Test plan
- **Straight-line retire:** reset, then 10 back-to-back valid MEM instructions with PC 0x40, 0x44, … → `o_insn_vld` high for 10 cycles starting 1 cycle later, `o_pc_debug` follows the PCs, instret reads 10.
- **Stall and flush:** `i_stall` in cycle 3 and `i_flush` in cycle 5 of the sequence → 2 bubbles, instret 8. A flushed instruction with ctrl and mispred set adds no ctrl or mispred counts.
- **Branch accounting:** 6 ctrl instructions, 2 of them mispredicted, plus 1 instruction with mispred set and ctrl clear → ctrl 6, mispred 2, `o_mispred` pulses exactly twice.
- **Halt:** retire PC 0x1C → `o_halt` = 1 on the next cycle. cycle and instret stay constant across 20 further cycles; the retire stream continues.
- **Read port and wrap:** preload (force) cycle to 0xFFFF_FFFF_FFFF_FFFF and read with addr 0 → lo 0xFFFF_FFFF then 0x0000_0000 after the wrap; hi 0x0000_0000 after the wrap. The data lags the address by 1 cycle.
- **Clear and reset:** `i_cnt_clr` together with an increment → counters read 0 and `o_halt` is unchanged. Assert `i_reset` mid-stream → all outputs 0 on the next cycle.
